// File: rtl/axon_scheduler.sv
// Spike-event scheduler: queues axon events, fetches one synapse word per event and presents it to the neuron array.
// Optional build macro SCHED_SKIP_ZERO_EN drops all-zero connection words instead of presenting them.
module axon_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        spk_valid_i,
    input  logic [7:0]  spk_axon_i,
    output logic        spk_ready_o,
    output logic        mem_req_o,
    output logic [7:0]  mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        conn_valid_o,
    output logic [7:0]  conn_axon_o,
    output logic [31:0] conn_data_o,
    input  logic        conn_ready_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int AXON_W = 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

    state_t             state_q, state_d;
    logic [AXON_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         wait_q, wait_d;
    logic               push, pop, capture, expire;

    always_comb begin
        push    = spk_valid_i && spk_ready_o && !clear_i;
        pop     = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    wait_d  = 8'd0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (mem_ack_i) begin
                    capture = 1'b1;
`ifdef SCHED_SKIP_ZERO_EN
                    state_d = (mem_data_i == 32'h0) ? IDLE : OUT;
`else
                    state_d = OUT;
`endif
                end else if (wait_q == WAIT_LAST) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            OUT: begin
                if (conn_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            pop     = 1'b0;
            capture = 1'b0;
            expire  = 1'b0;
            wait_d  = 8'd0;
            state_d = IDLE;
        end
        count_d = clear_i ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= spk_axon_i;
        end
    end

    // Outputs are registered from next-state values, so ready/busy track the post-edge occupancy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wait_q       <= 8'd0;
            spk_ready_o  <= 1'b0;
            busy_o       <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            conn_valid_o <= 1'b0;
            conn_axon_o  <= '0;
            conn_data_o  <= '0;
            timeout_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            spk_ready_o  <= (count_d < DEPTH_C);
            busy_o       <= (count_d != '0) || (state_d != IDLE);
            mem_req_o    <= (state_d == REQ);
            conn_valid_o <= (state_d == OUT);
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                mem_addr_o  <= fifo_mem[rd_ptr_q];
                conn_axon_o <= fifo_mem[rd_ptr_q];
            end
            if (capture) begin
                conn_data_o <= mem_data_i;
            end
            if (clear_i) begin
                timeout_o <= 1'b0;
            end else if (expire) begin
                timeout_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axon_scheduler.sv
// Directed self-checking bench for axon_scheduler (default parameters).
module tb_axon_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        spk_valid;
    logic [7:0]  spk_axon;
    logic        spk_ready;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] mem_data_drv;
    bit          auto_mem;
    logic        conn_valid;
    logic [7:0]  conn_axon;
    logic [31:0] conn_data;
    logic        conn_ready;
    logic        clear;
    logic        busy;
    logic        timeout;

    int n_chk = 0;
    int n_pass = 0;

    axon_scheduler #(.FIFO_DEPTH(8), .ACK_TIMEOUT(15)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .spk_valid_i(spk_valid), .spk_axon_i(spk_axon), .spk_ready_o(spk_ready),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .conn_valid_o(conn_valid), .conn_axon_o(conn_axon), .conn_data_o(conn_data),
        .conn_ready_i(conn_ready), .clear_i(clear), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // Memory model: in auto mode the word returned is a fixed pattern tagged with the address.
    always_comb mem_data = auto_mem ? {24'hD00D00, mem_addr} : mem_data_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, got, n_acc, seen;
        logic acc;
        logic [7:0] exp_axon [9];

        rst_n = 1'b0; spk_valid = 1'b0; spk_axon = 8'h0; mem_ack = 1'b0;
        mem_data_drv = 32'h0; auto_mem = 1'b0; conn_ready = 1'b0; clear = 1'b0;
        repeat (3) tick();
        chk("rst_ready", spk_ready, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_valid", conn_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_pre", spk_ready, 0);
        tick();
        chk("rel_ready", spk_ready, 1);

        // Single event, zero-wait ack.
        spk_valid = 1'b1; spk_axon = 8'h05; conn_ready = 1'b1;
        tick();
        spk_valid = 1'b0;
        chk("t0_req_nobypass", mem_req, 0);
        chk("t0_busy", busy, 1);
        mem_ack = 1'b1; mem_data_drv = 32'hA5A5_0001;
        tick();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 8'h05);
        tick();
        mem_ack = 1'b0;
        chk("t2_valid", conn_valid, 1);
        chk("t2_axon", conn_axon, 8'h05);
        chk("t2_data", conn_data, 32'hA5A5_0001);
        chk("t2_req", mem_req, 0);
        tick();
        chk("t3_valid", conn_valid, 0);
        chk("t3_busy", busy, 0);

        // Stall one word in OUT, then fill the FIFO.
        auto_mem = 1'b1; mem_ack = 1'b1; conn_ready = 1'b0;
        spk_valid = 1'b1; spk_axon = 8'hF0;
        tick();
        spk_valid = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("stall_valid", conn_valid, 1);
        chk("stall_axon", conn_axon, 8'hF0);
        exp_axon[0] = 8'hF0;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            spk_valid = 1'b1; spk_axon = 8'h10 + 8'(i);
            acc = spk_ready;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc <= 8) exp_axon[n_acc] = 8'h10 + 8'(i);
            end
            if (i == 7) chk("full_ready", spk_ready, 0);
        end
        chk("accepted", n_acc, 8);
        tick();
        chk("ninth_held", spk_ready, 0);
        spk_valid = 1'b0;
        conn_ready = 1'b1; mem_ack = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 9; c++) begin
            if (conn_valid) begin
                chk("ord_axon", conn_axon, exp_axon[got]);
                chk("ord_data", conn_data, {24'hD00D00, exp_axon[got]});
                got++;
            end
            tick();
        end
        chk("ord_count", got, 9);
        repeat (4) tick();
        chk("drain_busy", busy, 0);
        chk("drain_ready", spk_ready, 1);

        // Ack timeout, then a following event and the ack-on-last-cycle case.
        mem_ack = 1'b0;
        spk_valid = 1'b1; spk_axon = 8'h33;
        tick();
        spk_valid = 1'b0;
        tick();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 15);
        chk("to_flag", timeout, 1);
        chk("to_novalid", conn_valid, 0);
        spk_valid = 1'b1; spk_axon = 8'h34; mem_ack = 1'b1;
        tick();
        spk_valid = 1'b0;
        tick();
        tick();
        chk("to_next_valid", conn_valid, 1);
        chk("to_next_axon", conn_axon, 8'h34);
        chk("to_sticky", timeout, 1);
        mem_ack = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_timeout", timeout, 0);
        chk("clr_valid", conn_valid, 0);
        spk_valid = 1'b1; spk_axon = 8'h35;
        tick();
        spk_valid = 1'b0;
        tick();
        repeat (14) tick();
        chk("last_req", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("last_ack_valid", conn_valid, 1);
        chk("last_ack_axon", conn_axon, 8'h35);
        chk("last_ack_noto", timeout, 0);
        tick();

        // All-zero connection word.
        auto_mem = 1'b0; mem_data_drv = 32'h0; mem_ack = 1'b1;
        spk_valid = 1'b1; spk_axon = 8'h44;
        tick();
        spk_valid = 1'b0;
        tick();
        tick();
`ifdef SCHED_SKIP_ZERO_EN
        chk("zero_skip_valid", conn_valid, 0);
        chk("zero_skip_busy", busy, 0);
`else
        chk("zero_valid", conn_valid, 1);
        chk("zero_data", conn_data, 32'h0);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_busy_after", busy, 0);
`endif
        tick();

        // Reset in the middle of a request with three events queued.
        auto_mem = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spk_valid = 1'b1; spk_axon = 8'h50 + 8'(i);
            tick();
        end
        spk_valid = 1'b0;
        chk("mid_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", spk_ready, 0);
        chk("mid_rst_valid", conn_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_req || conn_valid) seen++;
        end
        chk("post_rst_stale", seen, 0);
        chk("post_rst_busy", busy, 0);

        // Clear with a simultaneous push while a word is presented.
        conn_ready = 1'b0;
        spk_valid = 1'b1; spk_axon = 8'h60;
        tick();
        spk_valid = 1'b0;
        tick();
        tick();
        chk("cp_out_valid", conn_valid, 1);
        clear = 1'b1; spk_valid = 1'b1; spk_axon = 8'h61;
        tick();
        clear = 1'b0; spk_valid = 1'b0;
        chk("cp_valid", conn_valid, 0);
        chk("cp_busy", busy, 0);
        chk("cp_ready", spk_ready, 1);
        conn_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_req || conn_valid) seen++;
        end
        chk("cp_lost", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
